// File: rtl/clock_time_pkg.sv
// Shared widths, count limits and FSM state type for the clock time keeper.
package clock_time_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_e;

  // Modulo-60 style increment shared by the seconds and minutes counters.
  function automatic logic [5:0] wrapInc6(input logic [5:0] value, input logic [5:0] maxValue);
    return (value == maxValue) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/clock_time_keeper_edge_sync.sv
// edge_sync: multi-stage synchronizer for one asynchronous input, followed by a
// rising-edge detector that emits a single-cycle pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulse is decoded from flops only, so downstream sees it SYNC_STAGES cycles after the edge.
  assign level_o = sync_q[SYNC_STAGES-1];
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_time_keeper.sv
// Time-of-day counter (hh:mm:ss) with a RUN/SET mode FSM and button-driven setting.
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_time_keeper
  import clock_time_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int HOUR_MODULUS = 24
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              tick_in,
  input  logic              set_mode,
  input  logic              inc_min,
  input  logic              inc_hour,
`ifdef CLOCK_ALARM_EN
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  output logic              alarm_on,
`endif
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              day_carry
);

  localparam logic [SEC_W-1:0]  SecMax  = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0]  MinMax  = MIN_W'(MIN_MAX);
  localparam logic [HOUR_W-1:0] HourMax = HOUR_W'(HOUR_MODULUS - 1);

  logic tickPulse;
  logic minPulse;
  logic hourPulse;
  logic setLevel;
  logic unusedTickLevel;
  logic unusedMinLevel;
  logic unusedHourLevel;
  logic unusedSetPulse;

  state_e            state_q, state_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              carry_q, carry_d;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uTickSync (
    .clk_i   (clock_in),
    .rst_ni  (reset_n),
    .async_i (tick_in),
    .level_o (unusedTickLevel),
    .pulse_o (tickPulse)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uMinSync (
    .clk_i   (clock_in),
    .rst_ni  (reset_n),
    .async_i (inc_min),
    .level_o (unusedMinLevel),
    .pulse_o (minPulse)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uHourSync (
    .clk_i   (clock_in),
    .rst_ni  (reset_n),
    .async_i (inc_hour),
    .level_o (unusedHourLevel),
    .pulse_o (hourPulse)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uSetSync (
    .clk_i   (clock_in),
    .rst_ni  (reset_n),
    .async_i (set_mode),
    .level_o (setLevel),
    .pulse_o (unusedSetPulse)
  );

  // A tick arriving in the same cycle as RUN->SET is dropped because the mode change wins.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    carry_d = 1'b0;
    case (state_q)
      RUN: begin
        if (setLevel) begin
          state_d = SET;
          sec_d   = '0;
        end else if (tickPulse) begin
          sec_d = wrapInc6(sec_q, SecMax);
          if (sec_q == SecMax) begin
            min_d = wrapInc6(min_q, MinMax);
            if (min_q == MinMax) begin
              if (hour_q == HourMax) begin
                hour_d  = '0;
                carry_d = 1'b1;
              end else begin
                hour_d = hour_q + 1'b1;
              end
            end
          end
        end
      end
      SET: begin
        sec_d = '0;
        if (minPulse) begin
          min_d = wrapInc6(min_q, MinMax);
        end
        if (hourPulse) begin
          hour_d = (hour_q == HourMax) ? '0 : hour_q + 1'b1;
        end
        if (!setLevel) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      carry_q <= carry_d;
    end
  end

  assign seconds   = sec_q;
  assign minutes   = min_q;
  assign hours     = hour_q;
  assign day_carry = carry_q;

`ifdef CLOCK_ALARM_EN
  logic alarm_q, alarm_d;

  // Compares the registered time, so the alarm follows the count by one cycle.
  always_comb begin
    alarm_d = (state_q == RUN) && (hour_q == alarm_hour) && (min_q == alarm_min);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_on = alarm_q;
`endif

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper: a 24-hour and a 12-hour instance share
// stimulus and are checked against a plain-arithmetic time-of-day model.
module tb_clock_time_keeper;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  logic tick_in  = 1'b0;
  logic set_mode = 1'b0;
  logic inc_min  = 1'b0;
  logic inc_hour = 1'b0;

  logic [5:0] sec24, min24, sec12, min12;
  logic [4:0] hr24, hr12;
  logic       carry24, carry12;
  logic [16:0] act24, act12;

`ifdef CLOCK_ALARM_EN
  logic [4:0] alarmHour = 5'd7;
  logic [5:0] alarmMin  = 6'd30;
  logic       alarm24, alarm12;
`endif

  int checks = 0;
  int fails  = 0;

  int mSec;
  int mMin;
  int mHr[2];
  bit mSet;
  bit mCarry[2];

  always #5 clock_in = ~clock_in;

  assign act24 = {hr24, min24, sec24};
  assign act12 = {hr12, min12, sec12};

  clock_time_keeper u24 (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .tick_in   (tick_in),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
`ifdef CLOCK_ALARM_EN
    .alarm_hour(alarmHour),
    .alarm_min (alarmMin),
    .alarm_on  (alarm24),
`endif
    .seconds   (sec24),
    .minutes   (min24),
    .hours     (hr24),
    .day_carry (carry24)
  );

  clock_time_keeper #(.HOUR_MODULUS(12)) u12 (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .tick_in   (tick_in),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
`ifdef CLOCK_ALARM_EN
    .alarm_hour(alarmHour),
    .alarm_min (alarmMin),
    .alarm_on  (alarm12),
`endif
    .seconds   (sec12),
    .minutes   (min12),
    .hours     (hr12),
    .day_carry (carry12)
  );

  // Reference model: time of day as plain integers, index 0 = 24h, index 1 = 12h.
  function automatic int modOf(input int idx);
    return (idx == 0) ? 24 : 12;
  endfunction

  function automatic void modelReset();
    mSec = 0;
    mMin = 0;
    mHr[0] = 0;
    mHr[1] = 0;
    mSet = 1'b0;
    mCarry[0] = 1'b0;
    mCarry[1] = 1'b0;
  endfunction

  function automatic void modelTick();
    if (mSet) return;
    mSec = (mSec + 1) % 60;
    if (mSec == 0) begin
      mMin = (mMin + 1) % 60;
      if (mMin == 0) begin
        for (int i = 0; i < 2; i++) mHr[i] = (mHr[i] + 1) % modOf(i);
      end
    end
    for (int i = 0; i < 2; i++) mCarry[i] = (mSec == 0) && (mMin == 0) && (mHr[i] == 0);
  endfunction

  function automatic void modelInc(input bit m, input bit h);
    if (!mSet) return;
    if (m) mMin = (mMin + 1) % 60;
    if (h) begin
      for (int i = 0; i < 2; i++) mHr[i] = (mHr[i] + 1) % modOf(i);
    end
  endfunction

  function automatic logic [16:0] expTime(input int idx);
    return {5'(mHr[idx]), 6'(mMin), 6'(mSec)};
  endfunction

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  // Raise the chosen inputs and wait until their effect is visible on the outputs.
  task automatic applyStimulus(input bit t, input bit m, input bit h);
    tick_in  = t;
    inc_min  = m;
    inc_hour = h;
    waitNeg(3);
    mCarry[0] = 1'b0;
    mCarry[1] = 1'b0;
    if (t) modelTick();
    modelInc(m, h);
  endtask

  task automatic releaseInputs();
    tick_in  = 1'b0;
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    waitNeg(2);
  endtask

  task automatic setMode(input bit v, input bit withTick);
    set_mode = v;
    tick_in  = withTick;
    waitNeg(3);
    mCarry[0] = 1'b0;
    mCarry[1] = 1'b0;
    if (v && !mSet) mSec = 0;
    mSet = v;
    tick_in = 1'b0;
    waitNeg(2);
  endtask

  task automatic pulseN(input int n, input bit t, input bit m, input bit h);
    for (int k = 0; k < n; k++) begin
      applyStimulus(t, m, h);
      releaseInputs();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    modelReset();
    waitNeg(2);
    checks++;
    if ({act24, carry24} !== 18'd0) begin
      fails++;
      $display("[TB] FAIL reset_hold24: got %h expected 0", {act24, carry24});
    end
    checks++;
    if ({act12, carry12} !== 18'd0) begin
      fails++;
      $display("[TB] FAIL reset_hold12: got %h expected 0", {act12, carry12});
    end
    reset_n = 1'b1;
    waitNeg(4);
    checks++;
    if (act24 !== 17'd0) begin
      fails++;
      $display("[TB] FAIL reset_release: got %h expected 0", act24);
    end
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 60; k++) begin
      tick_in = 1'b1;
      waitNeg(2);
      checks++;
      if (act24 !== expTime(0)) begin
        fails++;
        $display("[TB] FAIL tick_latency_early: got %h expected %h", act24, expTime(0));
      end
      waitNeg(1);
      modelTick();
      checks++;
      if (act24 !== expTime(0)) begin
        fails++;
        $display("[TB] FAIL tick_latency: got %h expected %h", act24, expTime(0));
      end
      tick_in = 1'b0;
      waitNeg(2);
    end
    checks++;
    if (act24 !== {5'd0, 6'd1, 6'd0}) begin
      fails++;
      $display("[TB] FAIL free_run_60: got %0d:%0d:%0d expected 0:1:0", hr24, min24, sec24);
    end
  endtask

  task automatic test_set_mode();
    setMode(1'b1, 1'b0);
    pulseN((10 - mHr[0] + 24) % 24, 1'b0, 1'b0, 1'b1);
    pulseN((20 - mMin + 60) % 60, 1'b0, 1'b1, 1'b0);
    setMode(1'b0, 1'b0);
    pulseN(35, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act24 !== {5'd10, 6'd20, 6'd35}) begin
      fails++;
      $display("[TB] FAIL set_to_10_20_35: got %0d:%0d:%0d expected 10:20:35", hr24, min24, sec24);
    end
    // Tick lands on the same cycle as entering SET and must be lost.
    setMode(1'b1, 1'b1);
    checks++;
    if (act24 !== {5'd10, 6'd20, 6'd0}) begin
      fails++;
      $display("[TB] FAIL set_entry_clear: got %0d:%0d:%0d expected 10:20:0", hr24, min24, sec24);
    end
    pulseN(3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act24 !== expTime(0)) begin
      fails++;
      $display("[TB] FAIL set_ticks_ignored: got %h expected %h", act24, expTime(0));
    end
    pulseN(40, 1'b0, 1'b1, 1'b0);
    checks++;
    if (act24 !== {5'd10, 6'd0, 6'd0}) begin
      fails++;
      $display("[TB] FAIL set_min_wrap: got %0d:%0d:%0d expected 10:0:0", hr24, min24, sec24);
    end
    pulseN(1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (act24 !== {5'd11, 6'd1, 6'd0}) begin
      fails++;
      $display("[TB] FAIL set_both: got %0d:%0d:%0d expected 11:1:0", hr24, min24, sec24);
    end
    checks++;
    if (act12 !== expTime(1)) begin
      fails++;
      $display("[TB] FAIL set_both12: got %h expected %h", act12, expTime(1));
    end
    setMode(1'b0, 1'b0);
    pulseN(1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act24 !== {5'd11, 6'd1, 6'd1}) begin
      fails++;
      $display("[TB] FAIL resume_run: got %0d:%0d:%0d expected 11:1:1", hr24, min24, sec24);
    end
  endtask

  task automatic test_day_wrap();
    setMode(1'b1, 1'b0);
    pulseN((23 - mHr[0] + 24) % 24, 1'b0, 1'b0, 1'b1);
    pulseN((59 - mMin + 60) % 60, 1'b0, 1'b1, 1'b0);
    setMode(1'b0, 1'b0);
    pulseN(59, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({act24, act12} !== {5'd23, 6'd59, 6'd59, 5'd11, 6'd59, 6'd59}) begin
      fails++;
      $display("[TB] FAIL pre_wrap: got %0d:%0d:%0d / %0d:%0d:%0d expected 23:59:59 / 11:59:59",
               hr24, min24, sec24, hr12, min12, sec12);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checks++;
    if ({act24, act12} !== 34'd0) begin
      fails++;
      $display("[TB] FAIL day_wrap: got %h / %h expected 0 / 0", act24, act12);
    end
    checks++;
    if ({carry24, carry12} !== {mCarry[0], mCarry[1]} || {carry24, carry12} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL day_carry_pulse: got %b%b expected 11", carry24, carry12);
    end
    waitNeg(1);
    checks++;
    if ({carry24, carry12} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL day_carry_width: got %b%b expected 00", carry24, carry12);
    end
    releaseInputs();
  endtask

  task automatic test_reset_mid_set();
    setMode(1'b1, 1'b0);
    pulseN(3, 1'b0, 1'b1, 1'b1);
    inc_min  = 1'b1;
    inc_hour = 1'b1;
    waitNeg(1);
    reset_n  = 1'b0;
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    set_mode = 1'b0;
    #1;
    checks++;
    if ({act24, act12} !== 34'd0) begin
      fails++;
      $display("[TB] FAIL reset_async: got %h / %h expected 0 / 0", act24, act12);
    end
    waitNeg(1);
    reset_n = 1'b1;
    modelReset();
    waitNeg(5);
    checks++;
    if ({act24, act12, carry24, carry12} !== 36'd0) begin
      fails++;
      $display("[TB] FAIL reset_no_stray: got %h / %h expected 0 / 0", act24, act12);
    end
    pulseN(1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act24 !== {5'd0, 6'd0, 6'd1}) begin
      fails++;
      $display("[TB] FAIL reset_back_in_run: got %0d:%0d:%0d expected 0:0:1", hr24, min24, sec24);
    end
  endtask

  task automatic test_tick_high_at_reset();
    reset_n = 1'b0;
    tick_in = 1'b1;
    waitNeg(2);
    reset_n = 1'b1;
    modelReset();
    waitNeg(3);
    modelTick();
    checks++;
    if (act24 !== expTime(0)) begin
      fails++;
      $display("[TB] FAIL tick_high_release: got %h expected %h", act24, expTime(0));
    end
    waitNeg(5);
    checks++;
    if (act24 !== {5'd0, 6'd0, 6'd1}) begin
      fails++;
      $display("[TB] FAIL tick_high_single: got %0d:%0d:%0d expected 0:0:1", hr24, min24, sec24);
    end
    tick_in = 1'b0;
    waitNeg(2);
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r == 8) begin
        setMode(!mSet, 1'b0);
      end else begin
        applyStimulus(r < 5 || r == 9, r == 5 || r == 7 || r == 9, r == 6 || r == 7);
        checks++;
        if ({carry24, carry12} !== {mCarry[0], mCarry[1]}) begin
          fails++;
          $display("[TB] FAIL random_carry op%0d: got %b%b expected %b%b",
                   k, carry24, carry12, mCarry[0], mCarry[1]);
        end
        releaseInputs();
      end
      checks++;
      if (act24 !== expTime(0) || act12 !== expTime(1)) begin
        fails++;
        $display("[TB] FAIL random_time op%0d: got %h / %h expected %h / %h",
                 k, act24, act12, expTime(0), expTime(1));
      end
      waitNeg($urandom_range(0, 3));
    end
    if (mSet) setMode(1'b0, 1'b0);
  endtask

`ifdef CLOCK_ALARM_EN
  task automatic test_alarm();
    reset_n = 1'b0;
    waitNeg(2);
    reset_n = 1'b1;
    modelReset();
    setMode(1'b1, 1'b0);
    pulseN(7, 1'b0, 1'b0, 1'b1);
    pulseN(29, 1'b0, 1'b1, 1'b0);
    setMode(1'b0, 1'b0);
    pulseN(59, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({alarm24, alarm12} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL alarm_early: got %b%b expected 00", alarm24, alarm12);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checks++;
    if ({alarm24, act24} !== {1'b0, 5'd7, 6'd30, 6'd0}) begin
      fails++;
      $display("[TB] FAIL alarm_latency: got %b %h expected 0 at 07:30:00", alarm24, act24);
    end
    waitNeg(1);
    checks++;
    if ({alarm24, alarm12} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL alarm_on: got %b%b expected 11", alarm24, alarm12);
    end
    releaseInputs();
    setMode(1'b1, 1'b0);
    checks++;
    if ({alarm24, alarm12} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL alarm_in_set: got %b%b expected 00", alarm24, alarm12);
    end
    setMode(1'b0, 1'b0);
    pulseN(60, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({alarm24, act24} !== {1'b0, 5'd7, 6'd31, 6'd0}) begin
      fails++;
      $display("[TB] FAIL alarm_off: got %b %h expected 0 at 07:31:00", alarm24, act24);
    end
  endtask
`endif

  initial begin
    modelReset();
    test_reset();
    test_free_run();
    test_set_mode();
    test_day_wrap();
    test_reset_mid_set();
    test_tick_high_at_reset();
    test_random();
`ifdef CLOCK_ALARM_EN
    test_alarm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/clock_time_keeper.md
CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (>=2) on every asynchronous input.
REQ-002 SHALL have parameter HOUR_MODULUS, default 24, giving the hour count modulus (legal values 12 or 24).
REQ-003 SHALL have port clock_in, input, 1 bit: the single system clock; all flops are on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick_in, input, 1 bit: divided square wave from the clock divider; each rising edge is one second.
REQ-006 SHALL have port set_mode, input, 1 bit: level; high selects time-setting mode.
REQ-007 SHALL have port inc_min, input, 1 bit: debounced button; each rising edge increments minutes in SET.
REQ-008 SHALL have port inc_hour, input, 1 bit: debounced button; each rising edge increments hours in SET.
REQ-009 SHALL have port seconds, output, 6 bits: binary 0..59.
REQ-010 SHALL have port minutes, output, 6 bits: binary 0..59.
REQ-011 SHALL have port hours, output, 5 bits: binary 0..HOUR_MODULUS-1.
REQ-012 SHALL have port day_carry, output, 1 bit: one-cycle pulse on wrap from max time to 00:00:00.

Function
REQ-013 SHALL pass tick_in, inc_min and inc_hour each through a SYNC_STAGES synchronizer and a rising-edge detector, producing one-clock pulses with latency SYNC_STAGES+1 cycles from the input edge.
REQ-014 SHALL implement a two-state FSM: RUN and SET.
REQ-015 SHALL move RUN->SET on the first cycle synchronized set_mode is high, and SET->RUN on the first cycle it is low.
REQ-016 In RUN, each tick pulse SHALL increment seconds; at 59 seconds SHALL wrap to 0 and minutes SHALL increment.
REQ-017 In RUN, on minutes wrap 59->0 hours SHALL increment; at HOUR_MODULUS-1 hours SHALL wrap to 0.
REQ-018 On the tick that wraps the time to 00:00:00, day_carry SHALL pulse for exactly one cycle, registered with the updated count.
REQ-019 In RUN, inc_min and inc_hour pulses SHALL be ignored.
REQ-020 On entry to SET, seconds SHALL clear to 0; throughout SET, tick pulses SHALL be ignored and seconds held at 0.
REQ-021 In SET, an inc_min pulse SHALL increment minutes, wrapping 59->0 with no carry into hours.
REQ-022 In SET, an inc_hour pulse SHALL increment hours modulo HOUR_MODULUS.
REQ-023 Simultaneous inc_min and inc_hour pulses in SET SHALL both be applied in the same cycle.
REQ-024 A tick pulse in the same cycle as the RUN->SET transition SHALL be dropped.
REQ-025 After SET->RUN, counting SHALL resume from the current minutes and hours with seconds = 0.
REQ-026 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 Asserting reset_n low SHALL asynchronously force seconds, minutes and hours to 0, day_carry to 0, the FSM to RUN, and all synchronizer and edge flops to 0.
REQ-028 Reset asserted mid-count or mid-SET SHALL abort the operation, with no pending pulse surviving it.
REQ-029 If tick_in is high at reset release, it SHALL produce exactly one seconds increment within SYNC_STAGES+1 cycles.

Configuration
REQ-030 With macro CLOCK_ALARM_EN defined, the module SHALL add these ports:
 - alarm_hour, input, 5 bits
 - alarm_min, input, 6 bits
 - alarm_on, output, 1 bit
REQ-031 With CLOCK_ALARM_EN defined, alarm_on SHALL be registered high while the FSM is in RUN, hours == alarm_hour and minutes == alarm_min, and low otherwise; reset value is 0; latency is 1 cycle.
REQ-032 Without CLOCK_ALARM_EN, the alarm ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package clock_time_pkg SHALL hold SEC_W=6, MIN_W=6, HOUR_W=5, SEC_MAX=59, MIN_MAX=59 and the FSM state enum (RUN, SET).
REQ-034 Sub-module edge_sync (synchronizer plus rising-edge pulse, parameter SYNC_STAGES) SHALL be instantiated once each for tick_in, inc_min, inc_hour and set_mode; set_mode uses the synchronized level only.

Verification
REQ-035 Free run: reset, then 60 tick_in edges -> seconds=0, minutes=1, hours=0; each edge is seen 3 cycles after tick_in rises.
REQ-036 Day wrap: set 23:59, return to RUN, 59 ticks to 23:59:59, then 1 tick -> 00:00:00 with day_carry high for exactly 1 cycle.
REQ-037 Set mode: set_mode=1 at 10:20:35 -> seconds=0 and ticks ignored; 40 inc_min pulses -> minutes=0, hours unchanged at 10; simultaneous inc_min+inc_hour -> 11:01.
REQ-038 HOUR_MODULUS=12: count from 11:59:59, 1 tick -> 00:00:00 with day_carry pulse.
REQ-039 Reset mid-SET: reset_n low for 1 cycle during SET with inc pulses in flight -> all outputs 0, FSM in RUN, no stray increment after release.
REQ-040 CLOCK_ALARM_EN with alarm 07:30: run from 07:29:59, 1 tick -> alarm_on high 1 cycle later; at 07:31:00 alarm_on low; in SET, alarm_on low.
